// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory bus between the instruction-fetch
// port and the MEM-stage data port. One request becomes one bus transaction;
// the result of each port is held until the pipeline advances.
//
// Bus handshake: bus_req_o is raised together with stable bus_we_o, bus_addr_o,
// bus_sel_o and bus_wdata_o and stays high until the cycle after bus_ack_i is
// seen high; a transaction completes in exactly the cycle where
// bus_req_o && bus_ack_i. bus_ack_i while bus_req_o is low is ignored.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_ce_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_data_o,
    output logic        if_stallreq_o,
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] mem_data_o,
    output logic        mem_stallreq_o,
    input  logic        advance_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,
    output logic        bus_err_o,
    output logic        dbg_state
);

    // Counter only needs to reach TIMEOUT-1; keep at least one bit.
    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]    state;
    logic          owner;      // 0 = instruction port, 1 = data port
    logic [CW-1:0] cnt;
    logic          held_i;
    logic          held_d;

    logic          pend_i;
    logic          pend_d;
    logic          ack_fire;
    logic          timeout_fire;
    logic          done;
    logic          set_i;
    logic          set_d;
    logic [31:0]   result;

    // A port with a held result must not reissue its access, so both the
    // arbitration and the stall requests look at the pre-clear held flags.
    assign pend_d = mem_ce_i & ~held_d;
    assign pend_i = if_ce_i & ~held_i;

    assign mem_stallreq_o = pend_d;
    assign if_stallreq_o  = pend_i;

    assign ack_fire     = (state == BUSY) && bus_ack_i;
    assign timeout_fire = (state == BUSY) && !bus_ack_i && (TIMEOUT != 0)
                          && (cnt == TO_LAST);
    assign done         = ack_fire | timeout_fire;
    assign set_d        = done & owner;
    assign set_i        = done & ~owner;

    // Writes and timeouts return zero; only an acked read returns bus data.
    assign result = (ack_fire && !bus_we_o) ? bus_rdata_i : 32'h0;

    assign dbg_state = state;

    // Transaction FSM: arbitration in IDLE, hold bus outputs stable in BUSY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            owner       <= 1'b0;
            cnt         <= '0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= 32'h0;
            bus_sel_o   <= 4'h0;
            bus_wdata_o <= 32'h0;
            bus_err_o   <= 1'b0;
        end else begin
            bus_err_o <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (pend_d) begin
                        state       <= BUSY;
                        owner       <= 1'b1;
                        bus_req_o   <= 1'b1;
                        bus_we_o    <= mem_we_i;
                        bus_addr_o  <= mem_addr_i;
                        bus_sel_o   <= mem_sel_i;
                        bus_wdata_o <= mem_data_i;
                    end else if (pend_i) begin
                        state       <= BUSY;
                        owner       <= 1'b0;
                        bus_req_o   <= 1'b1;
                        bus_we_o    <= 1'b0;
                        bus_addr_o  <= if_addr_i;
                        bus_sel_o   <= 4'hF;
                        bus_wdata_o <= 32'h0;
                    end
                end
                BUSY: begin
                    if (ack_fire) begin
                        state     <= IDLE;
                        bus_req_o <= 1'b0;
                        bus_we_o  <= 1'b0;
                        cnt       <= '0;
                    end else if (timeout_fire) begin
                        state     <= IDLE;
                        bus_req_o <= 1'b0;
                        bus_we_o  <= 1'b0;
                        bus_err_o <= 1'b1;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    bus_req_o <= 1'b0;
                    bus_we_o  <= 1'b0;
                    cnt       <= '0;
                end
            endcase
        end
    end

    // Held flags: completion sets, pipeline advance clears, set has priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_i <= 1'b0;
            held_d <= 1'b0;
        end else begin
            held_i <= set_i | (held_i & ~advance_i);
            held_d <= set_d | (held_d & ~advance_i);
        end
    end

    // Result registers keep the last completed value for each port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_data_o  <= 32'h0;
            mem_data_o <= 32'h0;
        end else begin
            if (set_i) begin
                if_data_o <= result;
            end
            if (set_d) begin
                mem_data_o <= result;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: table of single/dual-port accesses against a
// memory responder, plus hand-written timing, timeout, ack+advance and
// asynchronous-reset sequences. Bus transactions are checked against an
// expected queue filled when each request is driven.
module tb_mem_arbiter;

    localparam int TO = 16;
    localparam int W  = 69;  // {we, addr, sel, wdata}

    logic        clk;
    logic        rst;
    logic        if_ce_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_data_o;
    logic        if_stallreq_o;
    logic        mem_ce_i;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_data_i;
    logic [31:0] mem_data_o;
    logic        mem_stallreq_o;
    logic        advance_i;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i;
    logic        bus_ack_i;
    logic        bus_err_o;
    logic        dbg_state;

    typedef struct {
        logic        ce_i;
        logic        ce_d;
        logic        we;
        logic [31:0] addr_i;
        logic [31:0] addr_d;
        logic [3:0]  sel;
        logic [31:0] wdata;
        int          dly;
        logic [31:0] exp_if;
        logic [31:0] exp_mem;
    } vec_t;

    vec_t        vecs[6];
    logic [W-1:0] exp_q[$];
    logic [31:0] mem[logic [31:0]];
    int          errors = 0;
    int          checks = 0;
    int          txn_count = 0;
    bit          ack_en = 1'b1;
    int          ack_delay = 0;
    int          resp_cnt = 0;

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_ce_i        (if_ce_i),
        .if_addr_i      (if_addr_i),
        .if_data_o      (if_data_o),
        .if_stallreq_o  (if_stallreq_o),
        .mem_ce_i       (mem_ce_i),
        .mem_we_i       (mem_we_i),
        .mem_addr_i     (mem_addr_i),
        .mem_sel_i      (mem_sel_i),
        .mem_data_i     (mem_data_i),
        .mem_data_o     (mem_data_o),
        .mem_stallreq_o (mem_stallreq_o),
        .advance_i      (advance_i),
        .bus_req_o      (bus_req_o),
        .bus_we_o       (bus_we_o),
        .bus_addr_o     (bus_addr_o),
        .bus_sel_o      (bus_sel_o),
        .bus_wdata_o    (bus_wdata_o),
        .bus_rdata_i    (bus_rdata_i),
        .bus_ack_i      (bus_ack_i),
        .bus_err_o      (bus_err_o),
        .dbg_state      (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'h0;
    endfunction

    function automatic logic [W-1:0] pack_txn(input logic we, input logic [31:0] a,
                                              input logic [3:0] s, input logic [31:0] wd);
        return {we, a, s, (we ? wd : 32'h0)};
    endfunction

    // Memory responder: acks after ack_delay BUSY cycles, garbage data otherwise.
    initial begin
        bus_ack_i   = 1'b0;
        bus_rdata_i = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (!bus_req_o) begin
                resp_cnt    = 0;
                bus_ack_i   = 1'b0;
                bus_rdata_i = $urandom;
            end else if (ack_en && resp_cnt >= ack_delay && !bus_ack_i) begin
                bus_ack_i   = 1'b1;
                bus_rdata_i = mem_rd(bus_addr_o);
            end else begin
                bus_ack_i   = 1'b0;
                bus_rdata_i = $urandom;
                resp_cnt++;
            end
        end
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Negedge sample point; completed bus transactions are scored here.
    task automatic wait_neg();
        logic [W-1:0] got;
        logic [31:0]  old;
        @(negedge clk);
        if (bus_req_o && bus_ack_i) begin
            txn_count++;
            got = pack_txn(bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL bus_txn_unexpected: got %0h expected none", got);
            end else begin
                chk("bus_txn", got, exp_q.pop_front());
            end
            if (bus_we_o) begin
                old = mem_rd(bus_addr_o);
                for (int b = 0; b < 4; b++)
                    if (bus_sel_o[b]) old[8*b +: 8] = bus_wdata_o[8*b +: 8];
                mem[bus_addr_o] = old;
            end
        end
    endtask

    task automatic next_drive();
        @(posedge clk);
        #2;
    endtask

    task automatic tick();
        wait_neg();
        next_drive();
    endtask

    task automatic release_ports();
        advance_i = 1'b1;
        if_ce_i   = 1'b0;
        mem_ce_i  = 1'b0;
        tick();
        advance_i = 1'b0;
    endtask

    // One table entry: drive, wait for release, check results, check no reissue.
    task automatic run_vec(input vec_t v, input int k);
        int n;
        int start;
        bit done;
        ack_delay  = v.dly;
        if_ce_i    = v.ce_i;
        if_addr_i  = v.addr_i;
        mem_ce_i   = v.ce_d;
        mem_we_i   = v.we;
        mem_addr_i = v.addr_d;
        mem_sel_i  = v.sel;
        mem_data_i = v.wdata;
        if (v.ce_d) exp_q.push_back(pack_txn(v.we, v.addr_d, v.sel, v.wdata));
        if (v.ce_i) exp_q.push_back(pack_txn(1'b0, v.addr_i, 4'hF, 32'h0));
        start = txn_count;
        n = 0;
        done = 1'b0;
        while (!done && n < 60) begin
            wait_neg();
            if (!if_stallreq_o && !mem_stallreq_o) done = 1'b1;
            else begin
                next_drive();
                n++;
            end
        end
        chk($sformatf("v%0d_release", k), W'(done), W'(1));
        if (v.ce_i) chk($sformatf("v%0d_if_data", k), W'(if_data_o), W'(v.exp_if));
        if (v.ce_d) chk($sformatf("v%0d_mem_data", k), W'(mem_data_o), W'(v.exp_mem));
        for (int c = 0; c < 3; c++) begin
            next_drive();
            wait_neg();
            chk($sformatf("v%0d_hold_stall", k), W'({if_stallreq_o, mem_stallreq_o}), W'(0));
        end
        chk($sformatf("v%0d_txn_count", k), W'(txn_count - start), W'(int'(v.ce_i) + int'(v.ce_d)));
        chk($sformatf("v%0d_queue_empty", k), W'(exp_q.size()), W'(0));
        next_drive();
        release_ports();
    endtask

    initial begin
        int busy;
        int errc;
        rst        = 1'b1;
        if_ce_i    = 1'b0;
        if_addr_i  = 32'h0;
        mem_ce_i   = 1'b0;
        mem_we_i   = 1'b0;
        mem_addr_i = 32'h0;
        mem_sel_i  = 4'h0;
        mem_data_i = 32'h0;
        advance_i  = 1'b0;

        mem[32'h100] = 32'h2402_0005;
        mem[32'h104] = 32'h8C43_0004;
        mem[32'h108] = 32'hDEAD_BEEF;
        mem[32'h200] = 32'h1111_2222;
        mem[32'h500] = 32'hCAFE_F00D;
        mem[32'h600] = 32'h0600_AAAA;
        mem[32'h700] = 32'h0700_BBBB;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h100, 32'h0,        4'h0, 32'h0,        0, 32'h2402_0005, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h0,   32'h200,      4'hF, 32'h0,        1, 32'h0,         32'h1111_2222};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 32'h104, 32'h8000_0010, 4'h3, 32'h0000_ABCD, 0, 32'h8C43_0004, 32'h0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h108, 32'h8000_0010, 4'hF, 32'h0,        2, 32'hDEAD_BEEF, 32'h0000_ABCD};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 32'h0,   32'h300,      4'hC, 32'h1234_5678, 3, 32'h0,         32'h0};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 32'h0,   32'h300,      4'hF, 32'h0,        1, 32'h0,         32'h1234_0000};
        vecs[3].dly = $urandom_range(0, 3);
        vecs[5].dly = $urandom_range(0, 3);

        // Reset and reset-state checks
        repeat (3) tick();
        rst = 1'b0;
        wait_neg();
        chk("rst_bus_req", W'(bus_req_o), W'(0));
        chk("rst_bus_out", W'({bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o}), W'(0));
        chk("rst_bus_err", W'(bus_err_o), W'(0));
        chk("rst_data", W'({if_data_o, mem_data_o}), W'(0));
        chk("rst_stall", W'({if_stallreq_o, mem_stallreq_o}), W'(0));
        chk("rst_state", W'(dbg_state), W'(0));
        next_drive();

        // Table-driven accesses
        for (int k = 0; k < 6; k++) run_vec(vecs[k], k);

        // Both ports, zero-wait: data released at N+2, fetch at N+4
        ack_delay  = 0;
        if_ce_i    = 1'b1;
        if_addr_i  = 32'h600;
        mem_ce_i   = 1'b1;
        mem_we_i   = 1'b0;
        mem_addr_i = 32'h700;
        mem_sel_i  = 4'hF;
        exp_q.push_back(pack_txn(1'b0, 32'h700, 4'hF, 32'h0));
        exp_q.push_back(pack_txn(1'b0, 32'h600, 4'hF, 32'h0));
        wait_neg();
        chk("dual_n0_stall", W'({if_stallreq_o, mem_stallreq_o, bus_req_o}), W'(3'b110));
        next_drive();
        wait_neg();
        chk("dual_n1_req", W'({bus_req_o, bus_addr_o}), W'({1'b1, 32'h700}));
        next_drive();
        wait_neg();
        chk("dual_n2_stall", W'({if_stallreq_o, mem_stallreq_o, bus_req_o}), W'(3'b100));
        chk("dual_n2_mem_data", W'(mem_data_o), W'(32'h0700_BBBB));
        next_drive();
        wait_neg();
        chk("dual_n3_req", W'({bus_req_o, bus_addr_o, mem_stallreq_o}), W'({1'b1, 32'h600, 1'b0}));
        next_drive();
        wait_neg();
        chk("dual_n4_stall", W'({if_stallreq_o, bus_req_o}), W'(0));
        chk("dual_n4_if_data", W'(if_data_o), W'(32'h0600_AAAA));
        next_drive();
        release_ports();

        // Timeout: no ack, error pulse after TO BUSY cycles, result 0
        ack_en     = 1'b0;
        mem_ce_i   = 1'b1;
        mem_we_i   = 1'b0;
        mem_addr_i = 32'h400;
        mem_sel_i  = 4'hF;
        busy = 0;
        errc = 0;
        for (int c = 0; c < 25; c++) begin
            wait_neg();
            if (bus_req_o) busy++;
            if (bus_err_o) begin
                errc++;
                if (errc == 1) begin
                    chk("to_busy_cycles_at_err", W'(busy), W'(TO));
                    chk("to_mem_stall", W'(mem_stallreq_o), W'(0));
                    chk("to_mem_data", W'(mem_data_o), W'(0));
                end
            end
            next_drive();
        end
        chk("to_err_pulses", W'(errc), W'(1));
        chk("to_busy_total", W'(busy), W'(TO));
        release_ports();
        ack_en = 1'b1;
        run_vec(vecs[1], 6);

        // Ack and advance in the same cycle: set wins over clear
        ack_delay = 0;
        if_ce_i   = 1'b1;
        if_addr_i = 32'h500;
        exp_q.push_back(pack_txn(1'b0, 32'h500, 4'hF, 32'h0));
        wait_neg();
        next_drive();
        advance_i = 1'b1;
        wait_neg();
        chk("adv_ack_cycle", W'({bus_req_o, bus_ack_i}), W'(2'b11));
        next_drive();
        advance_i = 1'b0;
        wait_neg();
        chk("adv_if_stall", W'(if_stallreq_o), W'(0));
        chk("adv_if_data", W'(if_data_o), W'(32'hCAFE_F00D));
        next_drive();
        wait_neg();
        chk("adv_no_reissue", W'({bus_req_o, if_stallreq_o}), W'(0));
        next_drive();
        release_ports();

        // Asynchronous reset in the middle of a transaction
        ack_en     = 1'b0;
        mem_ce_i   = 1'b1;
        mem_we_i   = 1'b1;
        mem_addr_i = 32'h900;
        mem_sel_i  = 4'hF;
        mem_data_i = 32'h5555_AAAA;
        wait_neg();
        next_drive();
        wait_neg();
        chk("arst_busy_before", W'(bus_req_o), W'(1));
        #1;
        rst = 1'b1;
        #1;
        chk("arst_req_dropped", W'(bus_req_o), W'(0));
        mem_ce_i   = 1'b0;
        mem_we_i   = 1'b0;
        mem_addr_i = 32'h0;
        mem_sel_i  = 4'h0;
        mem_data_i = 32'h0;
        next_drive();
        rst    = 1'b0;
        ack_en = 1'b1;
        wait_neg();
        chk("arst_bus_out", W'({bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o, bus_err_o}), W'(0));
        chk("arst_data", W'({if_data_o, mem_data_o}), W'(0));
        chk("arst_state", W'(dbg_state), W'(0));
        next_drive();
        run_vec(vecs[0], 7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
